alu_decode_stage: RTL

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_decode_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
// Single-cycle RV32 decode stage: turns one instruction plus operands into ALU control,
// operands and writeback/branch info, behind a valid/ready output register.
module alu_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  ctrl,
    output logic [31:0] data0,
    output logic [31:0] data1,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        is_branch,
    output logic [31:0] branch_target,
    output logic        illegal
);

    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b0001;
    localparam logic [3:0] CTRL_SLL  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_SRL  = 4'b0100;
    localparam logic [3:0] CTRL_SRA  = 4'b0101;
    localparam logic [3:0] CTRL_OR   = 4'b0110;
    localparam logic [3:0] CTRL_AND  = 4'b0111;
    localparam logic [3:0] CTRL_BLT  = 4'b1000;
    localparam logic [3:0] CTRL_BGE  = 4'b1001;
    localparam logic [3:0] CTRL_BLTU = 4'b1010;
    localparam logic [3:0] CTRL_BGEU = 4'b1011;
    localparam logic [3:0] CTRL_BEQ  = 4'b1100;
    localparam logic [3:0] CTRL_BNE  = 4'b1101;
    localparam logic [3:0] CTRL_SLT  = 4'b1110;
    localparam logic [3:0] CTRL_SLTU = 4'b1111;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        funct7_ok;
    logic        is_shift;
    logic        capture;

    logic [3:0]  dec_ctrl;
    logic [31:0] dec_data0;
    logic [31:0] dec_data1;
    logic        dec_reg_write;
    logic        dec_is_branch;
    logic [31:0] dec_target;
    logic        dec_illegal;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'b0};
    assign shamt     = {27'b0, instr[24:20]};
    assign funct7_ok = (funct7 == 7'b0) || (funct7 == FUNCT7_ALT);
    assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);

    // alt selects SUB / SRA; it is ignored for every other funct3.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? CTRL_SUB : CTRL_ADD;
            3'b001:  op = CTRL_SLL;
            3'b010:  op = CTRL_SLT;
            3'b011:  op = CTRL_SLTU;
            3'b100:  op = CTRL_XOR;
            3'b101:  op = alt ? CTRL_SRA : CTRL_SRL;
            3'b110:  op = CTRL_OR;
            default: op = CTRL_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        dec_ctrl      = CTRL_ADD;
        dec_data0     = rs1_data;
        dec_data1     = rs2_data;
        dec_reg_write = 1'b0;
        dec_is_branch = 1'b0;
        dec_target    = 32'b0;
        dec_illegal   = 1'b0;

        case (opcode)
            OP_REG: begin
                dec_ctrl      = alu_op(funct3, funct7[5]);
                dec_reg_write = 1'b1;
                if ((funct3 == 3'b000 || funct3 == 3'b101) && !funct7_ok) begin
                    dec_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                // addi carries immediate bits in the funct7 field, so only srli/srai are checked
                dec_ctrl      = alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
                dec_data1     = is_shift ? shamt : imm_i;
                dec_reg_write = 1'b1;
                if ((funct3 == 3'b101) && !funct7_ok) begin
                    dec_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                dec_is_branch = 1'b1;
                dec_target    = pc + imm_b;
                case (funct3)
                    3'b000:  dec_ctrl = CTRL_BEQ;
                    3'b001:  dec_ctrl = CTRL_BNE;
                    3'b100:  dec_ctrl = CTRL_BLT;
                    3'b101:  dec_ctrl = CTRL_BGE;
                    3'b110:  dec_ctrl = CTRL_BLTU;
                    3'b111:  dec_ctrl = CTRL_BGEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_LUI: begin
                dec_data0     = 32'b0;
                dec_data1     = imm_u;
                dec_reg_write = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        if (dec_illegal) begin
            dec_ctrl      = CTRL_ADD;
            dec_reg_write = 1'b0;
            dec_is_branch = 1'b0;
            dec_target    = 32'b0;
        end
    end

    // flush beats capture, capture beats drain; otherwise the held result stays put
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            ctrl          <= 4'b0;
            data0         <= 32'b0;
            data1         <= 32'b0;
            rd            <= 5'b0;
            reg_write     <= 1'b0;
            is_branch     <= 1'b0;
            branch_target <= 32'b0;
            illegal       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid     <= 1'b1;
            ctrl          <= dec_ctrl;
            data0         <= dec_data0;
            data1         <= dec_data1;
            rd            <= instr[11:7];
            reg_write     <= dec_reg_write;
            is_branch     <= dec_is_branch;
            branch_target <= dec_target;
            illegal       <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
